// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// one-hot result codes packed as {gt, lt, eq}.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] GT   = 3'b100;
    localparam logic [2:0] LT   = 3'b010;
    localparam logic [2:0] EQ   = 3'b001;
    localparam logic [2:0] NONE = 3'b000;

endpackage

// File: rtl/chunk_compare.sv
// Unsigned magnitude compare of one CHUNK-bit slice pair.
module chunk_compare #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first,
// stopping at the first differing chunk. Signed mode flips the sign bit.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    state_t                              state_q, state_n;
    logic [IDX_W-1:0]                    idx_q, idx_n;
    logic [2:0]                          res_q, res_n;
    logic [WIDTH-1:0]                    a_q, b_q;
    logic                                smode_q;
    logic                                load;

    logic [NCHUNK-1:0][CHUNK-1:0]        a_ch, b_ch;
    logic [IDX_W-1:0]                    sel;
    logic [CHUNK-1:0]                    ca, cb;
    logic                                c_gt, c_lt, c_eq;

    assign a_ch = a_q;
    assign b_ch = b_q;
    // Packed chunk NCHUNK-1 holds the MSBs, so index k maps to NCHUNK-1-k.
    assign sel  = LAST - idx_q;

    always_comb begin
        ca = a_ch[sel];
        cb = b_ch[sel];
        if (smode_q && (idx_q == '0)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
    end

    chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
        .a  (ca),
        .b  (cb),
        .gt (c_gt),
        .lt (c_lt),
        .eq (c_eq)
    );

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        res_n   = res_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    res_n   = NONE;
                    state_n = CMP;
                end
            end
            CMP: begin
                if (c_gt) begin
                    res_n   = GT;
                    state_n = DONE;
                end else if (c_lt) begin
                    res_n   = LT;
                    state_n = DONE;
                end else if (c_eq && (idx_q == LAST)) begin
                    res_n   = EQ;
                    state_n = DONE;
                end else begin
                    idx_n   = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            res_q   <= NONE;
            a_q     <= '0;
            b_q     <= '0;
            smode_q <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            res_q   <= res_n;
            if (load) begin
                a_q     <= a;
                b_q     <= b;
                smode_q <= signed_mode;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign a_gt_b    = res_q[2];
    assign a_lt_b    = res_q[1];
    assign a_eq_b    = res_q[0];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed vector table plus hand sequences for stall, reset and a long
// mixed-mode random run against a behavioural reference compare.
module tb_serial_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic        a_gt_b, a_lt_b, a_eq_b;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vs;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    serial_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a_gt_b      (a_gt_b),
        .a_lt_b      (a_lt_b),
        .a_eq_b      (a_eq_b),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [15:0] x, input logic [15:0] y,
                                             input logic s);
        if (s) begin
            if ($signed(x) > $signed(y)) return F_GT;
            if ($signed(x) < $signed(y)) return F_LT;
        end else begin
            if (x > y) return F_GT;
            if (x < y) return F_LT;
        end
        return F_EQ;
    endfunction

    function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
        for (int k = 0; k < 4; k++)
            if (x[15-4*k -: 4] != y[15-4*k -: 4]) return k + 1;
        return 4;
    endfunction

    // Count edges after acceptance until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: out_valid never rose after %0d edges", lat);
        end
    endtask

    // Present a request, scramble the inputs once accepted, wait for the
    // result and let the drain edge return the FSM to IDLE.
    task automatic do_req(input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                          output int lat, output logic [2:0] flags);
        a = xa; b = xb; signed_mode = xs; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
        wait_done(lat);
        flags = {a_gt_b, a_lt_b, a_eq_b};
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        logic [2:0]  fl;
        logic [15:0] ra, rb;
        logic        rs;

        vecs[0]  = '{16'h1234, 16'h1234, 1'b0, F_EQ, 4};
        vecs[1]  = '{16'h8000, 16'h7FFF, 1'b0, F_GT, 1};
        vecs[2]  = '{16'h8000, 16'h7FFF, 1'b1, F_LT, 1};
        vecs[3]  = '{16'h12F0, 16'h12E0, 1'b0, F_GT, 3};
        vecs[4]  = '{16'hFFFF, 16'h0000, 1'b1, F_LT, 1};
        vecs[5]  = '{16'hFFFF, 16'h0000, 1'b0, F_GT, 1};
        vecs[6]  = '{16'h0001, 16'h0002, 1'b0, F_LT, 4};
        vecs[7]  = '{16'hFFFE, 16'hFFFF, 1'b1, F_LT, 4};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, F_EQ, 4};
        vecs[9]  = '{16'h7FFF, 16'h8000, 1'b1, F_GT, 1};
        vecs[10] = '{16'h0F00, 16'h0E00, 1'b1, F_GT, 2};
        vecs[11] = '{16'hF123, 16'hF124, 1'b1, F_LT, 4};

        // Reset with a request pending: it must be discarded.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 16'h1111; b = 16'h2222; signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1; in_valid = 1'b0; rst_n = 1'b1;
        check("rst in_ready", int'(in_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst flags", int'({a_gt_b, a_lt_b, a_eq_b}), 0);
        @(posedge clk); #1;
        check("post-rst idle", int'(busy), 0);

        foreach (vecs[i]) begin
            do_req(vecs[i].va, vecs[i].vb, vecs[i].vs, lat, fl);
            check($sformatf("vec%0d flags", i), int'(fl), int'(vecs[i].flags));
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
        end
        in_valid = 1'b0;

        // Consumer stall: result holds and a waiting request is not taken.
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h0001; b = 16'h0000;
        wait_done(lat);
        check("stall latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            check("stall flags", int'({a_gt_b, a_lt_b, a_eq_b}), int'(F_EQ));
            check("stall out_valid", int'(out_valid), 1);
            check("stall in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain in_ready", int'(in_ready), 1);
        check("drain out_valid", int'(out_valid), 0);
        check("idle flags hold", int'({a_gt_b, a_lt_b, a_eq_b}), int'(F_EQ));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("new accept busy", int'(busy), 1);
        check("new accept flags clr", int'({a_gt_b, a_lt_b, a_eq_b}), 0);
        wait_done(lat);
        check("new result flags", int'({a_gt_b, a_lt_b, a_eq_b}), int'(F_GT));
        check("new result latency", lat, 4);
        @(posedge clk); #1;

        // Reset on the compare edge of a request.
        a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst flags", int'({a_gt_b, a_lt_b, a_eq_b}), 0);
        check("midrst in_ready", int'(in_ready), 1);

        // Long mixed-mode run with in_valid held high throughout.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rs = 1'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
                2: rb = ra ^ 16'h8000;
                default: rb = 16'($urandom);
            endcase
            do_req(ra, rb, rs, lat, fl);
            check($sformatf("rand%0d flags a=%h b=%h s=%0d", i, ra, rb, rs),
                  int'(fl), int'(ref_flags(ra, rb, rs)));
            check($sformatf("rand%0d latency", i), lat, ref_lat(ra, rb));
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand width in bits.
REQ-002 Parameter CHUNK, default 4, SHALL set the bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  input  1  SHALL mean the a, b and signed_mode inputs carry a request.
REQ-006 in_ready  output  1  SHALL mean the block accepts a request this cycle.
REQ-007 a, b  input  WIDTH  SHALL be the operands.
REQ-008 signed_mode  input  1  SHALL select a two's-complement comparison when 1 and an unsigned comparison when 0.
REQ-009 out_valid  output  1  SHALL mean the result flags are valid.
REQ-010 out_ready  input  1  SHALL mean the consumer takes the result this cycle.
REQ-011 a_gt_b, a_lt_b, a_eq_b  output  1 each  SHALL be registered result flags.
REQ-012 busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, CMP and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 An acceptance occurs on an edge where in_valid and in_ready are both 1; it SHALL latch a, b and signed_mode, clear the chunk index to 0 (MSB chunk), clear all flags and enter CMP.
REQ-016 Changes on a, b or signed_mode after acceptance SHALL NOT affect the result in progress.
REQ-017 In CMP, each edge SHALL compare one chunk, MSB-first, with chunk index k covering bits [WIDTH-1-k*CHUNK -: CHUNK].
REQ-018 In signed mode, the MSB of chunk 0 SHALL be inverted on both operands before the unsigned chunk compare; no other chunk is altered.
REQ-019 If chunk k differs, the FSM SHALL set a_gt_b or a_lt_b, enter DONE and raise out_valid on the same edge (early termination).
REQ-020 If chunk NCHUNK-1 is equal, the FSM SHALL set a_eq_b and enter DONE; otherwise k SHALL increment.
REQ-021 Latency SHALL be k+1 edges from acceptance to out_valid=1, where k is the first differing chunk index or NCHUNK-1 when the operands are equal; the worst case is NCHUNK.
REQ-022 Exactly one flag SHALL be 1 while out_valid=1.
REQ-023 In DONE, out_valid and the flags SHALL hold stable until an edge with out_ready=1; that edge SHALL move the FSM to IDLE and clear out_valid.
REQ-024 The flags SHALL hold their last value in IDLE and SHALL be cleared only by reset or a new acceptance.
REQ-025 in_valid during CMP or DONE SHALL be ignored and SHALL NOT be queued.
REQ-026 The minimum request period SHALL be k+3 edges (accept, k+1 compare edges, drain), with no bubble-free overlap.

Reset
REQ-027 On an edge with rst_n=0, in any state including mid-CMP, the FSM SHALL go to IDLE, and out_valid, busy and all flags SHALL go to 0.
REQ-028 After reset, in_ready SHALL be 1 and the chunk index and operand registers SHALL be 0.
REQ-029 A request presented during the reset edge SHALL be discarded.

Structure
REQ-030 A shared package cmp_pkg SHALL hold the FSM state enum (IDLE, CMP, DONE) and the result-code constants (GT, LT, EQ).
REQ-031 A single combinational sub-module, chunk_compare, parametrised by CHUNK, SHALL return gt/lt/eq for one chunk pair; the parent SHALL instantiate it once and mux the chunk inputs by index.

Verification (WIDTH=16, CHUNK=4, out_ready=1 unless stated)
REQ-032 a=0x1234, b=0x1234, unsigned -> out_valid after 4 edges, a_eq_b=1.
REQ-033 a=0x8000, b=0x7FFF, unsigned -> out_valid after 1 edge, a_gt_b=1; the same operands in signed mode -> out_valid after 1 edge, a_lt_b=1.
REQ-034 a=0x12F0, b=0x12E0, unsigned -> out_valid after 3 edges, a_gt_b=1; a and b change during CMP -> result unchanged.
REQ-035 Result ready with out_ready=0 for 5 cycles and in_valid=1 with new operands -> flags stable, in_ready=0, no acceptance; out_ready=1 -> IDLE next edge, then the new request is accepted.
REQ-036 rst_n=0 for one edge during CMP of a=0xFFFF, b=0x0000 -> next cycle out_valid=0, busy=0, all flags 0, in_ready=1.
REQ-037 in_valid held high with a random sequence of 1000 operand pairs in mixed modes -> every result matches a reference compare, and the latency per request equals k+1.
